lock_attempt_ctrl: RTL and testbench
====================================

LOCK_ATTEMPT_CTRL -- requirements
Module: lock_attempt_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, digits per code entry.
REQ-002 SHALL have parameter MAX_FAIL, default 3, consecutive failures that trigger lockout.
REQ-003 SHALL have parameter CHECK_WAIT, default 4, cycles allowed for core_unlocked to assert after the last digit.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 64, base lockout duration.
REQ-005 SHALL have parameter ENTRY_TIMEOUT, default 32, idle cycles before an entry is abandoned.
REQ-006 SHALL have parameter OPEN_CYCLES, default 16, maximum cycles spent in OPEN.
REQ-007 SHALL have one clock; reset is synchronous and active-high.
REQ-008 Port clk, input, 1: rising-edge clock.
REQ-009 Port rst, input, 1: synchronous active-high reset.
REQ-010 Port key_valid, input, 1: keypad key event present.
REQ-011 Port key_code, input, 4: 0001-1001 digits 1-9, 1010 digit 0, 1101 cancel, 1110 set_passcode, 1111 no key.
REQ-012 Port key_ready, output, 1: controller accepts a key this cycle.
REQ-013 Port core_key, output, 4: key stream to the lock core; 1111 when idle.
REQ-014 Port core_unlocked, input, 1: unlocked flag from the lock core.
REQ-015 Port lockout, output, 1: high while keys are refused after repeated failures.
REQ-016 Port fail_count, output, 3: consecutive failed entries, saturating at 7.

Function
REQ-017 SHALL implement states IDLE, ENTRY, CHECK, LOCKOUT and OPEN.
REQ-018 SHALL accept a key when key_valid and key_ready are both high in the same cycle.
REQ-019 SHALL drive key_ready high in IDLE, ENTRY and OPEN, and low in CHECK, LOCKOUT and on any cancel-injection cycle.
REQ-020 SHALL place an accepted key other than 1111 on core_key for exactly the following cycle, and drive 1111 in all other cycles.
REQ-021 SHALL accept and discard a key_code of 1111 without counting or forwarding it.
REQ-022 SHALL, on an accepted digit in IDLE, move to ENTRY with digit count 1.
REQ-023 SHALL, in ENTRY, increment the digit count on each accepted digit, and on reaching DIGITS move to CHECK and start the window counter at 0.
REQ-024 SHALL treat a cancel key in IDLE or ENTRY as follows: forward it, clear the digit count, return to IDLE, and leave fail_count unchanged.
REQ-025 SHALL treat ENTRY_TIMEOUT cycles in ENTRY with no accepted key as follows: inject 1101 on core_key for one cycle, go to IDLE, and count no failure.
REQ-026 SHALL give a key accepted on the timeout cycle priority over the timeout, restarting the timeout count.
REQ-027 SHALL, in CHECK, go to OPEN and clear fail_count if core_unlocked is sampled high within CHECK_WAIT cycles.
REQ-028 SHALL, on CHECK window expiry, inject 1101 for one cycle and increment fail_count (saturating); it then goes to LOCKOUT if the new fail_count is at least MAX_FAIL, else to IDLE.
REQ-029 SHALL hold lockout high throughout LOCKOUT, then on expiry clear fail_count, drop lockout and return to IDLE.
REQ-030 SHALL, in OPEN, forward all keys, including 1110 and the digits that follow it, without counting them.
REQ-031 SHALL leave OPEN for IDLE on a forwarded cancel or after OPEN_CYCLES cycles, whichever comes first.
REQ-032 SHALL not alter fail_count or lockout state on keys received during OPEN.

Reset
REQ-033 SHALL, while rst is high, force state IDLE, core_key 1111, key_ready 0, lockout 0, fail_count 0, and clear all counters and the backoff level.
REQ-034 SHALL abandon any in-progress entry, check or lockout when rst is asserted mid-operation, and inject no cancel.
REQ-035 SHALL drive key_ready 1 on the first cycle after rst falls.

Configuration
REQ-036 SHALL, with LOCK_BACKOFF_EN defined, set the lockout duration to LOCKOUT_CYCLES shifted left by a 2-bit backoff level, i.e. x1, x2, x4 or x8.
REQ-037 SHALL, with LOCK_BACKOFF_EN defined, increment the backoff level at each lockout entry, saturate it at 3, and clear it only on a successful unlock.
REQ-038 SHALL, without LOCK_BACKOFF_EN, always use a lockout duration of LOCKOUT_CYCLES and contain no backoff register.

Verification
REQ-039 Digits 1,2,3,4 entered with core_unlocked pulsed 2 cycles after the 4th digit -> each digit on core_key one cycle after acceptance, state OPEN, fail_count=0.
REQ-040 Three 4-digit entries with core_unlocked held 0 -> 1101 injected after each window; fail_count 1, 2, 3; lockout=1 for 64 cycles with key_ready=0; then fail_count=0.
REQ-041 With LOCK_BACKOFF_EN, two consecutive lockouts without an unlock -> lockout lengths of 64 and then 128 cycles.
REQ-042 Digits 5,6 followed by 32 idle cycles -> 1101 injected once, state IDLE, fail_count unchanged; a key on cycle 32 -> forwarded and no timeout.
REQ-043 rst asserted during CHECK with fail_count=2 -> next cycle fail_count=0, core_key=1111, lockout=0, and no 1101 injected.
REQ-044 In OPEN, keys 1110,9,9,9,9 -> all forwarded unmodified; OPEN exits after 16 cycles with fail_count unchanged.

Source files
------------

// File: rtl/lock_attempt_ctrl.sv
// Keypad attempt controller in front of a lock core: entry timeout, unlock check window,
// failure lockout and an open session. Define LOCK_BACKOFF_EN for escalating lockout lengths.
module lock_attempt_ctrl #(
    parameter int DIGITS         = 4,
    parameter int MAX_FAIL       = 3,
    parameter int CHECK_WAIT     = 4,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int ENTRY_TIMEOUT  = 32,
    parameter int OPEN_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [3:0] core_key,
    input  logic       core_unlocked,
    output logic       lockout,
    output logic [2:0] fail_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_LOCKOUT,
        S_OPEN
    } state_t;

    localparam logic [3:0] KEY_NONE   = 4'hF;
    localparam logic [3:0] KEY_CANCEL = 4'hD;

    localparam int DW = $clog2(DIGITS + 1);
    localparam int WW = $clog2(CHECK_WAIT + 1);
    localparam int TW = $clog2(ENTRY_TIMEOUT + 1);
    localparam int OW = $clog2(OPEN_CYCLES + 1);
    // Sized for the largest backed-off lockout even when backoff is not built in.
    localparam int LW = $clog2(LOCKOUT_CYCLES * 8 + 1);

    localparam logic [DW-1:0] DIG_LAST     = DW'(DIGITS - 1);
    localparam logic [WW-1:0] WIN_LAST     = WW'(CHECK_WAIT - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [OW-1:0] OPEN_LAST    = OW'(OPEN_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCKOUT_CYCLES - 1);

    state_t        state_reg;
    logic [DW-1:0] digit_cnt_reg;
    logic [WW-1:0] win_cnt_reg;
    logic [TW-1:0] idle_cnt_reg;
    logic [OW-1:0] open_cnt_reg;
    logic [LW-1:0] lock_cnt_reg;

    logic          accept;
    logic          is_digit;
    logic          is_cancel;
    logic          entry_done;
    logic          to_lockout;
    logic [2:0]    fail_inc;
    logic [LW-1:0] lock_load;

    assign accept     = key_valid && key_ready;
    assign is_digit   = (key_code != 4'h0) && (key_code <= 4'hA);
    assign is_cancel  = (key_code == KEY_CANCEL);
    // In IDLE the digit count is zero, so a one-digit code completes straight from IDLE.
    assign entry_done = accept && is_digit && (digit_cnt_reg == DIG_LAST);
    assign fail_inc   = (fail_count == 3'd7) ? 3'd7 : fail_count + 3'd1;
    assign to_lockout = (int'(fail_inc) >= MAX_FAIL);

`ifdef LOCK_BACKOFF_EN
    logic [1:0] backoff_reg;
    // Lockout counter counts down from duration-1; duration doubles per backoff level.
    assign lock_load = LW'((LOCKOUT_CYCLES << backoff_reg) - 1);
`else
    assign lock_load = LOCK_LAST;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            digit_cnt_reg <= '0;
            win_cnt_reg   <= '0;
            idle_cnt_reg  <= '0;
            open_cnt_reg  <= '0;
            lock_cnt_reg  <= '0;
            core_key      <= KEY_NONE;
            key_ready     <= 1'b0;
            lockout       <= 1'b0;
            fail_count    <= 3'd0;
`ifdef LOCK_BACKOFF_EN
            backoff_reg   <= 2'd0;
`endif
        end else begin
            core_key  <= accept ? key_code : KEY_NONE;
            key_ready <= 1'b1;
            case (state_reg)
                S_IDLE, S_ENTRY: begin
                    if (entry_done) begin
                        state_reg     <= S_CHECK;
                        digit_cnt_reg <= '0;
                        win_cnt_reg   <= '0;
                        key_ready     <= 1'b0;
                    end else if (accept && is_digit) begin
                        state_reg     <= S_ENTRY;
                        digit_cnt_reg <= digit_cnt_reg + 1'b1;
                        idle_cnt_reg  <= '0;
                    end else if (accept && is_cancel) begin
                        state_reg     <= S_IDLE;
                        digit_cnt_reg <= '0;
                    end else if (accept) begin
                        idle_cnt_reg  <= '0;
                    end else if (state_reg == S_ENTRY && idle_cnt_reg == TIMEOUT_LAST) begin
                        // Abandoned entry: tell the core to drop its partial code.
                        core_key      <= KEY_CANCEL;
                        state_reg     <= S_IDLE;
                        digit_cnt_reg <= '0;
                        key_ready     <= 1'b0;
                    end else if (state_reg == S_ENTRY) begin
                        idle_cnt_reg  <= idle_cnt_reg + 1'b1;
                    end
                end
                S_CHECK: begin
                    key_ready <= 1'b0;
                    if (core_unlocked) begin
                        state_reg    <= S_OPEN;
                        fail_count   <= 3'd0;
                        open_cnt_reg <= '0;
                        key_ready    <= 1'b1;
`ifdef LOCK_BACKOFF_EN
                        backoff_reg  <= 2'd0;
`endif
                    end else if (win_cnt_reg == WIN_LAST) begin
                        core_key   <= KEY_CANCEL;
                        fail_count <= fail_inc;
                        if (to_lockout) begin
                            state_reg    <= S_LOCKOUT;
                            lockout      <= 1'b1;
                            lock_cnt_reg <= lock_load;
`ifdef LOCK_BACKOFF_EN
                            if (backoff_reg != 2'd3) begin
                                backoff_reg <= backoff_reg + 2'd1;
                            end
`endif
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        win_cnt_reg <= win_cnt_reg + 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (lock_cnt_reg == '0) begin
                        state_reg  <= S_IDLE;
                        lockout    <= 1'b0;
                        fail_count <= 3'd0;
                    end else begin
                        key_ready    <= 1'b0;
                        lock_cnt_reg <= lock_cnt_reg - 1'b1;
                    end
                end
                S_OPEN: begin
                    if ((accept && is_cancel) || open_cnt_reg == OPEN_LAST) begin
                        state_reg <= S_IDLE;
                    end else begin
                        open_cnt_reg <= open_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Self-checking bench for lock_attempt_ctrl: directed scenarios plus randomized traffic
// compared against a deadline-based reference model.
`timescale 1ns/1ps
module tb_lock_attempt_ctrl;
    localparam int DIGITS         = 4;
    localparam int MAX_FAIL       = 3;
    localparam int CHECK_WAIT     = 4;
    localparam int LOCKOUT_CYCLES = 64;
    localparam int ENTRY_TIMEOUT  = 32;
    localparam int OPEN_CYCLES    = 16;

    localparam logic [3:0] K_NONE   = 4'hF;
    localparam logic [3:0] K_CANCEL = 4'hD;
    localparam logic [3:0] K_SET    = 4'hE;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_CHECK = 2;
    localparam int M_LOCK  = 3;
    localparam int M_OPEN  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'hF;
    logic       core_unlocked = 1'b0;
    logic       key_ready;
    logic [3:0] core_key;
    logic       lockout;
    logic [2:0] fail_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase plus absolute-cycle deadlines.
    int         cyc = 0;
    int         m_mode = M_IDLE;
    int         m_digits = 0;
    int         m_deadline = 0;
    int         m_fail = 0;
    int         m_level = 0;
    logic [3:0] e_key = 4'hF;
    logic       e_ready = 1'b0;
    logic       e_lock = 1'b0;

    always #5 clk = ~clk;

    lock_attempt_ctrl #(
        .DIGITS(DIGITS), .MAX_FAIL(MAX_FAIL), .CHECK_WAIT(CHECK_WAIT),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .ENTRY_TIMEOUT(ENTRY_TIMEOUT), .OPEN_CYCLES(OPEN_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .core_key(core_key), .core_unlocked(core_unlocked),
        .lockout(lockout), .fail_count(fail_count)
    );

    function automatic logic [3:0] rand_digit();
        return 4'($urandom_range(1, 10));
    endfunction

    function automatic bit is_digit(input logic [3:0] k);
        return (k >= 4'd1) && (k <= 4'd10);
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [3:0] k, input logic u);
        bit acc;
        int dur;
        cyc++;
        if (r) begin
            m_mode = M_IDLE; m_digits = 0; m_fail = 0; m_level = 0;
            e_key = K_NONE; e_ready = 1'b0; e_lock = 1'b0;
            return;
        end
        acc = v && e_ready;
        e_key = acc ? k : K_NONE;
        e_ready = 1'b1;
        case (m_mode)
            M_IDLE, M_ENTRY: begin
                if (acc && is_digit(k)) begin
                    m_digits++;
                    if (m_digits == DIGITS) begin
                        m_mode = M_CHECK; m_digits = 0; e_ready = 1'b0;
                        m_deadline = cyc + CHECK_WAIT;
                    end else begin
                        m_mode = M_ENTRY; m_deadline = cyc + ENTRY_TIMEOUT;
                    end
                end else if (acc && k == K_CANCEL) begin
                    m_mode = M_IDLE; m_digits = 0;
                end else if (acc) begin
                    if (m_mode == M_ENTRY) m_deadline = cyc + ENTRY_TIMEOUT;
                end else if (m_mode == M_ENTRY && cyc == m_deadline) begin
                    e_key = K_CANCEL; m_mode = M_IDLE; m_digits = 0; e_ready = 1'b0;
                end
            end
            M_CHECK: begin
                e_ready = 1'b0;
                if (u) begin
                    m_mode = M_OPEN; m_fail = 0; m_level = 0; e_ready = 1'b1;
                    m_deadline = cyc + OPEN_CYCLES;
                end else if (cyc == m_deadline) begin
                    e_key = K_CANCEL;
                    m_fail = (m_fail >= 7) ? 7 : m_fail + 1;
                    if (m_fail >= MAX_FAIL) begin
`ifdef LOCK_BACKOFF_EN
                        dur = LOCKOUT_CYCLES << m_level;
                        m_level = (m_level >= 3) ? 3 : m_level + 1;
`else
                        dur = LOCKOUT_CYCLES;
`endif
                        m_mode = M_LOCK; e_lock = 1'b1; m_deadline = cyc + dur;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            end
            M_LOCK: begin
                if (cyc == m_deadline) begin
                    m_mode = M_IDLE; e_lock = 1'b0; m_fail = 0;
                end else begin
                    e_ready = 1'b0;
                end
            end
            default: begin
                if ((acc && k == K_CANCEL) || cyc == m_deadline) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic tick(input logic v, input logic [3:0] k, input logic u);
        key_valid = v; key_code = k; core_unlocked = u;
        @(posedge clk);
        model_edge(rst, v, k, u);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, K_NONE, 1'b0);
        tick(1'b0, K_NONE, 1'b0);
        rst = 1'b0;
        tick(1'b0, K_NONE, 1'b0);
    endtask

    // One wrong code left to run out its check window; optional trailing idle cycle.
    task automatic fail_entry(input bit extra);
        for (int i = 0; i < DIGITS; i++) tick(1'b1, rand_digit(), 1'b0);
        for (int i = 0; i < CHECK_WAIT; i++) tick(1'b0, K_NONE, 1'b0);
        if (extra) tick(1'b0, K_NONE, 1'b0);
    endtask

    task automatic count_lockout(output int n, output int ready_hi, output int fwd);
        n = (lockout === 1'b1) ? 1 : 0; ready_hi = 0; fwd = 0;
        for (int i = 0; i < 2000; i++) begin
            tick(1'b1, rand_digit(), 1'b0);
            if (core_key !== K_NONE) fwd++;
            if (lockout !== 1'b1) break;
            n++;
            if (key_ready !== 1'b0) ready_hi++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'd3, 1'b1);
            n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", key_ready); end
            n_cmp++; if (core_key !== K_NONE) begin n_bad++; $display("FAIL reset_key: got %h want f", core_key); end
            n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL reset_lockout: got %b want 0", lockout); end
            n_cmp++; if (fail_count !== 3'd0) begin n_bad++; $display("FAIL reset_fail: got %0d want 0", fail_count); end
        end
        rst = 1'b0;
        tick(1'b0, K_NONE, 1'b0);
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", key_ready); end
        $display("test_reset done");
    endtask

    task automatic test_unlock();
        logic [3:0] d;
        int delay;
        do_reset();
        fail_entry(1'b1);
        n_cmp++; if (fail_count !== 3'd1) begin n_bad++; $display("FAIL unlock_prefail: got %0d want 1", fail_count); end
        for (int i = 0; i < DIGITS; i++) begin
            d = rand_digit();
            tick(1'b1, d, 1'b0);
            n_cmp++; if (core_key !== d) begin n_bad++; $display("FAIL unlock_digit%0d: got %h want %h", i, core_key, d); end
        end
        delay = $urandom_range(1, CHECK_WAIT);
        for (int j = 1; j < delay; j++) tick(1'b0, K_NONE, 1'b0);
        tick(1'b0, K_NONE, 1'b1);
        n_cmp++; if (fail_count !== 3'd0) begin n_bad++; $display("FAIL unlock_fail_clear: got %0d want 0", fail_count); end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL unlock_ready: got %b want 1", key_ready); end
        for (int i = 0; i < DIGITS; i++) tick(1'b1, rand_digit(), 1'b0);
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL unlock_open_nocount: got %b want 1", key_ready); end
        $display("test_unlock done (delay %0d)", delay);
    endtask

    task automatic test_open();
        logic [3:0] keys [5];
        logic [3:0] d;
        keys = '{K_SET, 4'd9, 4'd9, 4'd9, 4'd9};
        do_reset();
        for (int i = 0; i < DIGITS; i++) tick(1'b1, rand_digit(), 1'b0);
        tick(1'b0, K_NONE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, keys[i], 1'b0);
            n_cmp++; if (core_key !== keys[i]) begin n_bad++; $display("FAIL open_fwd%0d: got %h want %h", i, core_key, keys[i]); end
            n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL open_ready%0d: got %b want 1", i, key_ready); end
        end
        for (int c = 6; c <= 12; c++) tick(1'b0, K_NONE, 1'b0);
        for (int c = 13; c <= OPEN_CYCLES + DIGITS; c++) begin
            d = rand_digit();
            tick(1'b1, d, 1'b0);
            n_cmp++; if (core_key !== d) begin n_bad++; $display("FAIL open_digit_c%0d: got %h want %h", c, core_key, d); end
            n_cmp++;
            if (key_ready !== (c < OPEN_CYCLES + DIGITS)) begin
                n_bad++; $display("FAIL open_exit_c%0d: ready got %b want %b", c, key_ready, c < OPEN_CYCLES + DIGITS);
            end
            if (c == OPEN_CYCLES) begin
                n_cmp++; if (fail_count !== 3'd0) begin n_bad++; $display("FAIL open_fail_kept: got %0d want 0", fail_count); end
            end
        end
        for (int i = 0; i < CHECK_WAIT; i++) tick(1'b0, K_NONE, 1'b0);
        n_cmp++; if (core_key !== K_CANCEL) begin n_bad++; $display("FAIL open_after_inject: got %h want d", core_key); end
        n_cmp++; if (fail_count !== 3'd1) begin n_bad++; $display("FAIL open_after_fail: got %0d want 1", fail_count); end
        $display("test_open done");
    endtask

    task automatic test_lockout();
        int n, ready_hi, fwd;
        do_reset();
        for (int e = 1; e <= MAX_FAIL; e++) begin
            for (int i = 0; i < DIGITS; i++) tick(1'b1, rand_digit(), 1'b0);
            for (int w = 1; w <= CHECK_WAIT; w++) begin
                tick(1'b0, K_NONE, 1'b0);
                if (w < CHECK_WAIT) begin
                    n_cmp++; if (core_key !== K_NONE) begin n_bad++; $display("FAIL lock_window%0d_%0d: got %h want f", e, w, core_key); end
                end
            end
            n_cmp++; if (core_key !== K_CANCEL) begin n_bad++; $display("FAIL lock_inject%0d: got %h want d", e, core_key); end
            n_cmp++; if (fail_count !== 3'(e)) begin n_bad++; $display("FAIL lock_fail%0d: got %0d want %0d", e, fail_count, e); end
            n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL lock_inject_ready%0d: got %b want 0", e, key_ready); end
            n_cmp++; if (lockout !== (e >= MAX_FAIL)) begin n_bad++; $display("FAIL lock_flag%0d: got %b want %b", e, lockout, e >= MAX_FAIL); end
            if (e < MAX_FAIL) begin
                tick(1'b0, K_NONE, 1'b0);
                n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL lock_ready_back%0d: got %b want 1", e, key_ready); end
            end
        end
        count_lockout(n, ready_hi, fwd);
        n_cmp++; if (n != LOCKOUT_CYCLES) begin n_bad++; $display("FAIL lock_len: got %0d want %0d", n, LOCKOUT_CYCLES); end
        n_cmp++; if (ready_hi != 0) begin n_bad++; $display("FAIL lock_ready_low: got %0d high cycles want 0", ready_hi); end
        n_cmp++; if (fwd != 0) begin n_bad++; $display("FAIL lock_no_fwd: got %0d forwarded want 0", fwd); end
        n_cmp++; if (fail_count !== 3'd0) begin n_bad++; $display("FAIL lock_exit_fail: got %0d want 0", fail_count); end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL lock_exit_ready: got %b want 1", key_ready); end
        $display("test_lockout done (len %0d)", n);
    endtask

`ifdef LOCK_BACKOFF_EN
    task automatic test_backoff();
        int n, ready_hi, fwd;
        do_reset();
        for (int l = 0; l < 2; l++) begin
            fail_entry(1'b1);
            fail_entry(1'b1);
            fail_entry(1'b0);
            count_lockout(n, ready_hi, fwd);
            n_cmp++;
            if (n != (LOCKOUT_CYCLES << l)) begin
                n_bad++; $display("FAIL backoff_len%0d: got %0d want %0d", l, n, LOCKOUT_CYCLES << l);
            end
        end
        $display("test_backoff done");
    endtask
`endif

    task automatic test_timeout();
        do_reset();
        fail_entry(1'b1);
        tick(1'b1, 4'd5, 1'b0);
        tick(1'b1, 4'd6, 1'b0);
        for (int i = 1; i <= ENTRY_TIMEOUT; i++) begin
            tick(1'b0, K_NONE, 1'b0);
            n_cmp++;
            if (core_key !== ((i == ENTRY_TIMEOUT) ? K_CANCEL : K_NONE)) begin
                n_bad++; $display("FAIL timeout_idle%0d: got %h", i, core_key);
            end
        end
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL timeout_inject_ready: got %b want 0", key_ready); end
        n_cmp++; if (fail_count !== 3'd1) begin n_bad++; $display("FAIL timeout_fail_kept: got %0d want 1", fail_count); end
        tick(1'b0, K_NONE, 1'b0);
        n_cmp++; if (core_key !== K_NONE) begin n_bad++; $display("FAIL timeout_once: got %h want f", core_key); end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL timeout_ready_back: got %b want 1", key_ready); end
        tick(1'b1, 4'd5, 1'b0);
        tick(1'b1, 4'd6, 1'b0);
        for (int i = 1; i < ENTRY_TIMEOUT; i++) tick(1'b0, K_NONE, 1'b0);
        tick(1'b1, 4'd7, 1'b0);
        n_cmp++; if (core_key !== 4'd7) begin n_bad++; $display("FAIL timeout_key_wins: got %h want 7", core_key); end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL timeout_key_ready: got %b want 1", key_ready); end
        for (int i = 1; i <= ENTRY_TIMEOUT; i++) begin
            tick(1'b0, K_NONE, 1'b0);
            n_cmp++;
            if (core_key !== ((i == ENTRY_TIMEOUT) ? K_CANCEL : K_NONE)) begin
                n_bad++; $display("FAIL timeout_restart%0d: got %h", i, core_key);
            end
        end
        tick(1'b0, K_NONE, 1'b0);
        for (int i = 0; i < DIGITS - 1; i++) tick(1'b1, rand_digit(), 1'b0);
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL timeout_count_clear: got %b want 1", key_ready); end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_check();
        do_reset();
        fail_entry(1'b1);
        fail_entry(1'b1);
        n_cmp++; if (fail_count !== 3'd2) begin n_bad++; $display("FAIL midrst_prefail: got %0d want 2", fail_count); end
        for (int i = 0; i < DIGITS; i++) tick(1'b1, rand_digit(), 1'b0);
        tick(1'b0, K_NONE, 1'b0);
        tick(1'b0, K_NONE, 1'b0);
        rst = 1'b1;
        tick(1'b0, K_NONE, 1'b0);
        n_cmp++; if (fail_count !== 3'd0) begin n_bad++; $display("FAIL midrst_fail: got %0d want 0", fail_count); end
        n_cmp++; if (core_key !== K_NONE) begin n_bad++; $display("FAIL midrst_key: got %h want f", core_key); end
        n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL midrst_lockout: got %b want 0", lockout); end
        rst = 1'b0;
        for (int i = 0; i < CHECK_WAIT + 2; i++) begin
            tick(1'b0, K_NONE, 1'b0);
            n_cmp++; if (core_key !== K_NONE) begin n_bad++; $display("FAIL midrst_no_inject%0d: got %h want f", i, core_key); end
        end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", key_ready); end
        $display("test_reset_mid_check done");
    endtask

    task automatic test_random();
        logic       v, u;
        logic [3:0] k;
        int         r, dens;
        do_reset();
        dens = 70;
        for (int c = 0; c < 6000; c++) begin
            if (c % 100 == 0) dens = ($urandom_range(0, 2) == 0) ? 3 : ($urandom_range(0, 1) ? 40 : 85);
            v = ($urandom_range(0, 99) < dens);
            r = $urandom_range(0, 99);
            if (r < 70) k = rand_digit();
            else if (r < 80) k = K_CANCEL;
            else if (r < 85) k = K_SET;
            else if (r < 92) k = K_NONE;
            else if (r < 96) k = 4'h0;
            else k = 4'($urandom_range(11, 12));
            u = ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 999) == 0);
            tick(v, k, u);
            n_cmp++; if (core_key !== e_key) begin n_bad++; $display("FAIL rand_key c%0d: got %h want %h", c, core_key, e_key); end
            n_cmp++; if (key_ready !== e_ready) begin n_bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, key_ready, e_ready); end
            n_cmp++; if (lockout !== e_lock) begin n_bad++; $display("FAIL rand_lockout c%0d: got %b want %b", c, lockout, e_lock); end
            n_cmp++; if (fail_count !== 3'(m_fail)) begin n_bad++; $display("FAIL rand_fail c%0d: got %0d want %0d", c, fail_count, m_fail); end
        end
        rst = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_open();
        test_lockout();
`ifdef LOCK_BACKOFF_EN
        test_backoff();
`endif
        test_timeout();
        test_reset_mid_check();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
